// File: rtl/accelerator_state_controller.sv
// Sequencer for the state-space accelerator: walks C/D then A/B rows per step,
// counts returned row results and commits x(k+1). Optional counters: ACCELERATOR_STATE_CONTROLLER_PERF_EN.
module accelerator_state_controller #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    BUSY,
    output logic                    ERROR,
    input  logic [DATA_SIZE-1:0]    SIZE_N_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_P_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_Q_IN,
    input  logic [DATA_SIZE-1:0]    STEPS_IN,
    output logic                    U_REQUEST,
    input  logic                    U_LOADED,
    output logic                    MAC_VALID,
    input  logic                    MAC_READY,
    output logic [1:0]              MAC_MATRIX,
    output logic [DATA_SIZE-1:0]    MAC_ROW,
    output logic [DATA_SIZE-1:0]    MAC_COL,
    output logic                    MAC_VECTOR,
    output logic                    MAC_FIRST,
    output logic                    MAC_LAST,
    input  logic                    MAC_RESULT_VALID,
    output logic                    X_SWAP,
    output logic [DATA_SIZE-1:0]    STEP_OUT,
    output logic [CONTROL_SIZE-1:0] PHASE_OUT
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
    ,
    output logic [DATA_SIZE-1:0]    CYCLE_COUNT_OUT,
    output logic [DATA_SIZE-1:0]    STALL_COUNT_OUT
`endif
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_U  = 3'd1,
        S_ISSUE_Y = 3'd2,
        S_ISSUE_X = 3'd3,
        S_DRAIN   = 3'd4,
        S_SWAP    = 3'd5
    } state_t;

    localparam logic [DATA_SIZE-1:0] ONE = {{(DATA_SIZE-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   n_q, n_d, p_q, p_d, q_q, q_d, k_q, k_d;
    logic [DATA_SIZE-1:0]   step_q, step_d, row_q, row_d, col_q, col_d;
    logic [DATA_SIZE-1:0]   res_cnt_q, res_cnt_d;
    logic                   part_q, part_d, error_q, error_d;
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
    logic [DATA_SIZE-1:0]   cycle_cnt_q, cycle_cnt_d, stall_cnt_q, stall_cnt_d;
`endif

    logic                   issuing, xfer, term_last, seq_done, res_inc;
    logic                   bad_cfg, accept, last_step;
    logic [DATA_SIZE-1:0]   row_last_idx, res_next;

    // part_q selects the u-vector half of a row (D or B terms).
    assign issuing      = (state_q == S_ISSUE_Y) || (state_q == S_ISSUE_X);
    assign xfer         = issuing && MAC_READY;
    assign row_last_idx = ((state_q == S_ISSUE_Y) ? q_q : n_q) - ONE;
    assign term_last    = part_q ? (col_q == p_q - ONE)
                                 : ((col_q == n_q - ONE) && (p_q == '0));
    assign seq_done     = xfer && term_last && (row_q == row_last_idx);
    assign res_inc      = MAC_RESULT_VALID && (state_q != S_IDLE) && (state_q != S_SWAP);
    assign res_next     = res_cnt_q + (res_inc ? ONE : '0);
    assign bad_cfg      = (SIZE_N_IN == '0) || (SIZE_Q_IN == '0) || (STEPS_IN == '0);
    assign accept       = (state_q == S_IDLE) && START && !bad_cfg;
    assign last_step    = (step_q + ONE) == k_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            p_q       <= '0;
            q_q       <= '0;
            k_q       <= '0;
            step_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            part_q    <= 1'b0;
            res_cnt_q <= '0;
            error_q   <= 1'b0;
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            p_q       <= p_d;
            q_q       <= q_d;
            k_q       <= k_d;
            step_q    <= step_d;
            row_q     <= row_d;
            col_q     <= col_d;
            part_q    <= part_d;
            res_cnt_q <= res_cnt_d;
            error_q   <= error_d;
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_WAIT_U;
            S_WAIT_U:  if (U_LOADED) state_d = S_ISSUE_Y;
            S_ISSUE_Y: if (seq_done) state_d = S_ISSUE_X;
            S_ISSUE_X: if (seq_done) state_d = S_DRAIN;
            S_DRAIN:   if (res_next == q_q + n_q) state_d = S_SWAP;
            S_SWAP:    state_d = last_step ? S_IDLE : S_WAIT_U;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        n_d       = n_q;
        p_d       = p_q;
        q_d       = q_q;
        k_d       = k_q;
        step_d    = step_q;
        row_d     = row_q;
        col_d     = col_q;
        part_d    = part_q;
        res_cnt_d = res_next;
        error_d   = (state_q == S_IDLE) && START && bad_cfg;
        if (accept) begin
            n_d       = SIZE_N_IN;
            p_d       = SIZE_P_IN;
            q_d       = SIZE_Q_IN;
            k_d       = STEPS_IN;
            step_d    = '0;
            res_cnt_d = '0;
        end
        if (state_q == S_WAIT_U) begin
            row_d  = '0;
            col_d  = '0;
            part_d = 1'b0;
        end
        // Row wraps to 0 at the end of ISSUE_Y so ISSUE_X starts without a bubble.
        if (xfer) begin
            if (term_last) begin
                col_d  = '0;
                part_d = 1'b0;
                row_d  = (row_q == row_last_idx) ? '0 : row_q + ONE;
            end else if (!part_q && (col_q == n_q - ONE)) begin
                col_d  = '0;
                part_d = 1'b1;
            end else begin
                col_d  = col_q + ONE;
            end
        end
        if (state_q == S_SWAP) begin
            res_cnt_d = '0;
            if (!last_step) step_d = step_q + ONE;
        end
    end

`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            cycle_cnt_d = ONE;
            stall_cnt_d = '0;
        end else begin
            if (state_q != S_IDLE) cycle_cnt_d = cycle_cnt_q + ONE;
            if (issuing && !MAC_READY) stall_cnt_d = stall_cnt_q + ONE;
        end
    end

    assign CYCLE_COUNT_OUT = cycle_cnt_q;
    assign STALL_COUNT_OUT = stall_cnt_q;
`endif

    always_comb begin
        READY      = 1'b0;
        BUSY       = (state_q != S_IDLE);
        ERROR      = error_q;
        U_REQUEST  = (state_q == S_WAIT_U);
        MAC_VALID  = 1'b0;
        MAC_MATRIX = 2'd0;
        MAC_ROW    = '0;
        MAC_COL    = '0;
        MAC_VECTOR = 1'b0;
        MAC_FIRST  = 1'b0;
        MAC_LAST   = 1'b0;
        X_SWAP     = 1'b0;
        STEP_OUT   = step_q;
        PHASE_OUT  = CONTROL_SIZE'(state_q);
        if (issuing) begin
            MAC_VALID  = 1'b1;
            MAC_MATRIX = (state_q == S_ISSUE_Y) ? (part_q ? 2'd3 : 2'd2)
                                                : (part_q ? 2'd1 : 2'd0);
            MAC_ROW    = row_q;
            MAC_COL    = col_q;
            MAC_VECTOR = part_q;
            MAC_FIRST  = !part_q && (col_q == '0);
            MAC_LAST   = term_last;
        end
        if (state_q == S_SWAP) begin
            X_SWAP = 1'b1;
            READY  = last_step;
        end
    end
endmodule

// File: tb/tb_accelerator_state_controller.sv
// Scoreboard bench for accelerator_state_controller: expected MAC operations and
// swap events are queued by a reference sequence model and popped by a monitor.
module tb_accelerator_state_controller;
    localparam int DW = 64;

    logic          CLK = 1'b0;
    logic          RST, START, U_LOADED, MAC_READY, MAC_RESULT_VALID;
    logic [DW-1:0] SIZE_N_IN, SIZE_P_IN, SIZE_Q_IN, STEPS_IN;
    logic          READY, BUSY, ERROR, U_REQUEST, MAC_VALID, MAC_VECTOR, MAC_FIRST, MAC_LAST, X_SWAP;
    logic [1:0]    MAC_MATRIX;
    logic [DW-1:0] MAC_ROW, MAC_COL, STEP_OUT;
    logic [3:0]    PHASE_OUT;
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
    logic [DW-1:0] CYCLE_COUNT_OUT, STALL_COUNT_OUT;
`endif

    accelerator_state_controller dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .BUSY(BUSY), .ERROR(ERROR),
        .SIZE_N_IN(SIZE_N_IN), .SIZE_P_IN(SIZE_P_IN), .SIZE_Q_IN(SIZE_Q_IN), .STEPS_IN(STEPS_IN),
        .U_REQUEST(U_REQUEST), .U_LOADED(U_LOADED), .MAC_VALID(MAC_VALID), .MAC_READY(MAC_READY),
        .MAC_MATRIX(MAC_MATRIX), .MAC_ROW(MAC_ROW), .MAC_COL(MAC_COL), .MAC_VECTOR(MAC_VECTOR),
        .MAC_FIRST(MAC_FIRST), .MAC_LAST(MAC_LAST), .MAC_RESULT_VALID(MAC_RESULT_VALID),
        .X_SWAP(X_SWAP), .STEP_OUT(STEP_OUT), .PHASE_OUT(PHASE_OUT)
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
        , .CYCLE_COUNT_OUT(CYCLE_COUNT_OUT), .STALL_COUNT_OUT(STALL_COUNT_OUT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]    m;
        logic [DW-1:0] row;
        logic [DW-1:0] col;
        logic          vec;
        logic          first;
        logic          last;
    } op_t;

    typedef struct packed {
        logic [DW-1:0] step;
        logic          rdy;
    } evt_t;

    op_t  exp_ops[$];
    evt_t exp_evt[$];
    int   checks = 0, errors = 0;
    int   xfer_count = 0, stall_seen = 0, stall_at = -1, stall_len = 0;
    int   res_delay = 2;
    bit   err_ok = 0;
    logic [1:0] pipe = 2'b00;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_op(input int m, input int r, input int c, input bit v, input bit f, input bit l);
        op_t o;
        o.m = 2'(m); o.row = DW'(r); o.col = DW'(c); o.vec = v; o.first = f; o.last = l;
        exp_ops.push_back(o);
    endtask

    // Reference order: C/D rows for y, then A/B rows for x(k+1).
    task automatic push_run(input int n, input int p, input int q, input int k);
        evt_t e;
        for (int s = 0; s < k; s++) begin
            for (int i = 0; i < q; i++) begin
                for (int c = 0; c < n; c++) push_op(2, i, c, 0, c == 0, (c == n - 1) && (p == 0));
                for (int c = 0; c < p; c++) push_op(3, i, c, 1, 0, c == p - 1);
            end
            for (int i = 0; i < n; i++) begin
                for (int c = 0; c < n; c++) push_op(0, i, c, 0, c == 0, (c == n - 1) && (p == 0));
                for (int c = 0; c < p; c++) push_op(1, i, c, 1, 0, c == p - 1);
            end
            e.step = DW'(s); e.rdy = (s == k - 1);
            exp_evt.push_back(e);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer or swap.
    initial begin
        op_t  cur, held;
        evt_t e;
        bit   held_v;
        held_v = 0;
        forever begin
            @(negedge CLK);
            cur = {MAC_MATRIX, MAC_ROW, MAC_COL, MAC_VECTOR, MAC_FIRST, MAC_LAST};
            if (held_v && MAC_VALID) check("hold", cur, held);
            held_v = 0;
            if (MAC_VALID && MAC_READY) begin
                xfer_count++;
                if (exp_ops.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL op_unexpected: got %0h expected none", cur);
                end else check("op", cur, exp_ops.pop_front());
            end else if (MAC_VALID) begin
                stall_seen++;
                held = cur;
                held_v = 1;
            end
            if (X_SWAP) begin
                if (exp_evt.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL swap_unexpected: got step %0d expected none", STEP_OUT);
                end else begin
                    e = exp_evt.pop_front();
                    check("swap_step", STEP_OUT, e.step);
                    check("swap_ready", READY, e.rdy);
                end
            end else if (READY) begin
                checks++; errors++;
                $display("FAIL ready_without_swap: got 1 expected 0");
            end
            if (ERROR && !err_ok) begin
                checks++; errors++;
                $display("FAIL error_unexpected: got 1 expected 0");
            end
        end
    end

    initial begin
        MAC_READY = 1'b1;
        forever begin
            @(posedge CLK); #1;
            MAC_READY = !(xfer_count == stall_at && stall_seen < stall_len);
        end
    end

    initial begin
        bit lx;
        MAC_RESULT_VALID = 1'b0;
        forever begin
            @(negedge CLK);
            lx = MAC_VALID && MAC_READY && MAC_LAST;
            @(posedge CLK); #1;
            pipe = {pipe[0], lx};
            MAC_RESULT_VALID = (res_delay == 1) ? pipe[0] : pipe[1];
        end
    end

    initial begin
        U_LOADED = 1'b0;
        forever begin
            @(negedge CLK);
            U_LOADED = U_REQUEST;
        end
    end

    task automatic start_run(input int n, input int p, input int q, input int k);
        @(posedge CLK); #1;
        SIZE_N_IN = DW'(n); SIZE_P_IN = DW'(p); SIZE_Q_IN = DW'(q); STEPS_IN = DW'(k);
        xfer_count = 0; stall_seen = 0;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy, output int drain);
        bit done;
        busy = 0; drain = 0; done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge CLK);
            if (!BUSY) done = 1;
            else begin
                busy++;
                if (PHASE_OUT == 4'd4) drain++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL run_timeout: got busy after %0d cycles expected idle", budget);
        end
    endtask

    task automatic wait_phase(input int step, input int phase, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge CLK);
            if (STEP_OUT == DW'(step) && PHASE_OUT == 4'(phase)) hit = 1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL phase_timeout: got step %0d phase %0d expected step %0d phase %0d",
                     STEP_OUT, PHASE_OUT, step, phase);
        end
    endtask

    task automatic check_empty(input string name);
        check({name, "_ops_left"}, exp_ops.size(), 0);
        check({name, "_evt_left"}, exp_evt.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy, drain;
        RST = 1'b1; START = 1'b0;
        SIZE_N_IN = '0; SIZE_P_IN = '0; SIZE_Q_IN = '0; STEPS_IN = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_ready", READY, 0);
        check("rst_error", ERROR, 0);
        check("rst_ureq", U_REQUEST, 0);
        check("rst_valid", MAC_VALID, 0);
        check("rst_swap", X_SWAP, 0);
        check("rst_step", STEP_OUT, 0);
        check("rst_phase", PHASE_OUT, 0);

        // Basic N=2 P=1 Q=1 K=1
        push_run(2, 1, 1, 1);
        start_run(2, 1, 1, 1);
        wait_done(200, busy, drain);
        check("t1_busy_cycles", busy, 13);
        check("t1_drain_cycles", drain, 2);
        check_empty("t1");
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
        check("t1_cycle_count", CYCLE_COUNT_OUT, 14);
        check("t1_stall_count", STALL_COUNT_OUT, 0);
`endif

        // Backpressure on the second operation
        stall_at = 1; stall_len = 3;
        push_run(2, 1, 1, 1);
        start_run(2, 1, 1, 1);
        wait_done(200, busy, drain);
        check("t2_busy_cycles", busy, 16);
        check("t2_stalls", stall_seen, 3);
        check_empty("t2");
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
        check("t2_stall_count", STALL_COUNT_OUT, 3);
        check("t2_cycle_count", CYCLE_COUNT_OUT, 17);
`endif
        stall_at = -1; stall_len = 0;

        // P=0, three steps
        push_run(2, 0, 2, 3);
        start_run(2, 0, 2, 3);
        wait_done(500, busy, drain);
        check("t3_busy_cycles", busy, 36);
        check_empty("t3");

        // Rejected START
        err_ok = 1;
        @(posedge CLK); #1;
        SIZE_N_IN = 2; SIZE_P_IN = 1; SIZE_Q_IN = 0; STEPS_IN = 1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        check("t4_error_pulse", ERROR, 1);
        check("t4_busy", BUSY, 0);
        @(negedge CLK);
        check("t4_error_clear", ERROR, 0);
        check("t4_busy_after", BUSY, 0);
        err_ok = 0;

        // START while issuing is ignored
        push_run(2, 1, 1, 1);
        start_run(2, 1, 1, 1);
        wait_phase(0, 3, 50);
        @(posedge CLK); #1;
        SIZE_N_IN = 5; SIZE_Q_IN = 0;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        check("t4_ignored_error", ERROR, 0);
        check("t4_ignored_busy", BUSY, 1);
        wait_done(200, busy, drain);
        check_empty("t4");

        // Reset in ISSUE_X of step 1
        push_run(2, 1, 1, 4);
        start_run(2, 1, 1, 4);
        wait_phase(1, 3, 100);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("t5_ctrl", {READY, BUSY, ERROR, U_REQUEST, MAC_VALID, MAC_MATRIX,
                          MAC_VECTOR, MAC_FIRST, MAC_LAST, X_SWAP}, 0);
        check("t5_row", MAC_ROW, 0);
        check("t5_col", MAC_COL, 0);
        check("t5_step", STEP_OUT, 0);
        check("t5_phase", PHASE_OUT, 0);
        @(posedge CLK); #1;
        exp_ops.delete();
        exp_evt.delete();
        repeat (3) @(posedge CLK);
        push_run(2, 1, 1, 1);
        start_run(2, 1, 1, 1);
        wait_done(200, busy, drain);
        check("t5_restart_busy", busy, 13);
        check_empty("t5");

        // Final result arrives on the first DRAIN cycle
        res_delay = 1;
        push_run(2, 1, 1, 1);
        start_run(2, 1, 1, 1);
        wait_done(200, busy, drain);
        check("t6_busy_cycles", busy, 12);
        check("t6_drain_cycles", drain, 1);
        check_empty("t6");
`ifdef ACCELERATOR_STATE_CONTROLLER_PERF_EN
        check("t6_cycle_count", CYCLE_COUNT_OUT, 13);
`endif
        res_delay = 2;

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/accelerator_state_controller.md
Name: accelerator_state_controller

Overview:
Sequencer for the state-space accelerator. It computes y(k) = C·x(k) + D·u(k) and x(k+1) = A·x(k) + B·u(k) for a programmed number of steps. Each step it requests u(k), then issues a stream of multiply-accumulate operations, one matrix element per operation, to the shared MAC datapath. It counts the returned row results and commits x(k+1) with a swap pulse. It holds no matrix or vector data; it produces only indices, operand selects and handshakes.

Parameters:
DATA_SIZE, 64, width of size, step and index fields
CONTROL_SIZE, 4, width of step-phase status field

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
START  input  1  begin run; sampled in IDLE only
READY  output  1  one-cycle pulse when run completes
BUSY  output  1  high whenever state != IDLE
ERROR  output  1  one-cycle pulse when START is rejected
SIZE_N_IN  input  DATA_SIZE  state dimension N
SIZE_P_IN  input  DATA_SIZE  input dimension P
SIZE_Q_IN  input  DATA_SIZE  output dimension Q
STEPS_IN  input  DATA_SIZE  number of steps K
U_REQUEST  output  1  level; asks datapath to load u(k)
U_LOADED  input  1  one-cycle pulse; u(k) is loaded
MAC_VALID  output  1  operation valid
MAC_READY  input  1  datapath accepts operation
MAC_MATRIX  output  2  0=A, 1=B, 2=C, 3=D
MAC_ROW  output  DATA_SIZE  matrix row index
MAC_COL  output  DATA_SIZE  matrix column index = vector index
MAC_VECTOR  output  1  0=x(k), 1=u(k)
MAC_FIRST  output  1  first term of row; clears the accumulator
MAC_LAST  output  1  last term of row; produces a result
MAC_RESULT_VALID  input  1  one-cycle pulse per completed row, in issue order
X_SWAP  output  1  one-cycle pulse; shadow x becomes x(k+1)
STEP_OUT  output  DATA_SIZE  current k
PHASE_OUT  output  CONTROL_SIZE  encoded current state

Behaviour:
- Reset (synchronous, RST=1 at a clock edge):
  - State goes to IDLE, counters clear.
  - All outputs are 0, including READY, ERROR and X_SWAP.
  - Applies mid-run too: any outstanding operation or result is abandoned, and MAC_RESULT_VALID is ignored until the next run.
- States: IDLE(0), WAIT_U(1), ISSUE_Y(2), ISSUE_X(3), DRAIN(4), SWAP(5).
- IDLE:
  - START with N=0, Q=0 or K=0: ERROR pulses the next cycle and the state stays IDLE.
  - Otherwise sizes and K are latched, STEP_OUT=0, and the state goes to WAIT_U the next cycle.
- WAIT_U:
  - U_REQUEST=1.
  - On U_LOADED, go to ISSUE_Y the next cycle; U_REQUEST drops with the transition.
- ISSUE_Y: for each row i in 0..Q-1, issue C[i][0..N-1] with vector x, then D[i][0..P-1] with vector u.
- ISSUE_X: for each row i in 0..N-1, issue A[i][0..N-1] with vector x, then B[i][0..P-1] with vector u.
- Issue handshake:
  - An operation transfers on MAC_VALID & MAC_READY.
  - While MAC_VALID=1 and MAC_READY=0, all MAC_* fields hold stable.
  - Back-to-back transfer is possible every cycle.
- Row flags:
  - MAC_FIRST=1 on column 0 of the C or A term.
  - MAC_LAST=1 on the final term: the last D/B column, or the last C/A column when P=0.
  - P=0 skips the D and B terms entirely.
- Sequence transitions:
  - After the last ISSUE_Y transfer, the next cycle is ISSUE_X with no bubble.
  - After the last ISSUE_X transfer, go to DRAIN.
- Result counting:
  - A result counter increments on each MAC_RESULT_VALID in WAIT_U, ISSUE_Y, ISSUE_X or DRAIN.
  - Results may arrive while issuing.
  - In DRAIN, when the count reaches Q+N (a pulse in the same cycle counts), go to SWAP.
- SWAP:
  - X_SWAP=1 for one cycle; the result counter clears.
  - If STEP_OUT+1 = K: READY=1 in this cycle, STEP_OUT holds, and the state goes to IDLE.
  - Otherwise STEP_OUT increments and the state goes to WAIT_U.
- START outside IDLE is ignored.
- Counters are DATA_SIZE wide; sizes are unsigned. The result count does not wrap for any N+Q < 2^DATA_SIZE.
- Operation counts per step:
  - Operations issued = Q·(N+P) + N·(N+P).
  - Minimum step latency with MAC_READY=1 and immediate results = 1 (WAIT_U, U_LOADED same cycle) + ops + 1 (DRAIN) + 1 (SWAP).

Optional Feature:
ACCELERATOR_STATE_CONTROLLER_PERF_EN
- When defined, two extra outputs are added, each DATA_SIZE wide:
  - CYCLE_COUNT_OUT: cycles from the START-accept cycle through the READY cycle inclusive.
  - STALL_COUNT_OUT: cycles with MAC_VALID=1 and MAC_READY=0.
- Both clear on RST and on accepted START, and hold their value after READY.
- When undefined, neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- N=2, P=1, Q=1, K=1; MAC_READY=1; U_LOADED on the first WAIT_U cycle; results returned 2 cycles after each LAST.
  - Required: 9 consecutive transfers, in order (matrix,row,col) = C00 C01 D00 A00 A01 B00 A10 A11 B10.
  - FIRST on C00, A00, A10; LAST on D00, B00, B10.
  - One X_SWAP, then READY, then BUSY=0.
- Same config with MAC_READY low for 3 cycles on the 2nd operation.
  - Required: C01 fields held stable for 3 cycles, total order unchanged.
  - With PERF_EN: STALL_COUNT_OUT=3.
- N=2, P=0, Q=2, K=3.
  - Required: 8 ops per step with no D or B terms; LAST on column 1.
  - STEP_OUT runs 0,1,2; 3 X_SWAP pulses; READY once, in the SWAP cycle of step 2.
- START with Q=0 -> ERROR pulse, BUSY stays 0.
  - START asserted during ISSUE_X -> ignored, no ERROR.
- RST asserted for one cycle in ISSUE_X of step 1 with K=4.
  - Required: next cycle all outputs 0, state IDLE.
  - A new START then restarts at STEP_OUT=0 with C00.
- Result arriving in the same cycle the DRAIN state is entered, completing Q+N.
  - Required: X_SWAP on the following cycle, no extra wait.
